// File: rtl/microwave_cook_ctrl.sv
// rtl/microwave_cook_ctrl.sv - microwave cook-cycle controller with BCD mm:ss countdown
module microwave_cook_ctrl #(
  parameter int TICK_DIV = 50000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  input  logic        start_btn,
  input  logic        stop_btn,
  input  logic        door_closed,
  output logic        magnetron_on,
  output logic        lamp_on,
  output logic        done,
  output logic [15:0] time_bcd,
  output logic [2:0]  state
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] P_MAX = PW'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SET   = 3'd1,
    S_COOK  = 3'd2,
    S_PAUSE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t          cur_state, nxt_state;
  logic [15:0]     time_q, time_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic            key_ok;
  logic            tick;
  logic [15:0]     time_dec;

  assign key_ok   = key_valid && (key_code <= 4'd9);
  assign tick     = (presc_q == P_MAX);
  assign state    = cur_state;
  assign time_bcd = time_q;

  // One-second BCD decrement with borrow; seconds above 59 are not normalized
  function automatic logic [15:0] dec_time(input logic [15:0] t);
    logic [3:0] mt, mo, st, so;
    {mt, mo, st, so} = t;
    if (so != 4'd0) begin
      so = so - 4'd1;
    end else if (st != 4'd0) begin
      st = st - 4'd1;
      so = 4'd9;
    end else if (mo != 4'd0) begin
      mo = mo - 4'd1;
      st = 4'd5;
      so = 4'd9;
    end else begin
      mt = mt - 4'd1;
      mo = 4'd9;
      st = 4'd5;
      so = 4'd9;
    end
    return {mt, mo, st, so};
  endfunction

  assign time_dec = dec_time(time_q);

  // Next-state, next-time and next-prescaler; stop > door open > start > key
  always_comb begin
    nxt_state = cur_state;
    time_d    = time_q;
    presc_d   = presc_q;
    case (cur_state)
      S_IDLE: begin
        if (!stop_btn && !start_btn && key_ok) begin
          time_d    = {12'h000, key_code};
          nxt_state = S_SET;
        end
      end
      S_SET: begin
        if (stop_btn) begin
          time_d    = 16'h0000;
          nxt_state = S_IDLE;
        end else if (start_btn) begin
          if (door_closed && (time_q != 16'h0000)) begin
            presc_d   = '0;
            nxt_state = S_COOK;
          end
        end else if (key_ok) begin
          time_d = {time_q[11:0], key_code};
        end
      end
      S_COOK: begin
        if (stop_btn || !door_closed) begin
          nxt_state = S_PAUSE;
        end else if (tick) begin
          presc_d = '0;
          time_d  = time_dec;
          if (time_dec == 16'h0000) begin
            nxt_state = S_DONE;
          end
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end
      S_PAUSE: begin
        if (stop_btn) begin
          time_d    = 16'h0000;
          presc_d   = '0;
          nxt_state = S_IDLE;
        end else if (start_btn && door_closed) begin
          nxt_state = S_COOK;
        end
      end
      S_DONE: begin
        time_d = 16'h0000;
        if (stop_btn || !door_closed || start_btn || key_ok) begin
          nxt_state = S_IDLE;
        end
      end
      default: begin
        time_d    = 16'h0000;
        presc_d   = '0;
        nxt_state = S_IDLE;
      end
    endcase
  end

  // State, time, prescaler and outputs registered from the next state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur_state    <= S_IDLE;
      time_q       <= 16'h0000;
      presc_q      <= '0;
      magnetron_on <= 1'b0;
      lamp_on      <= 1'b0;
      done         <= 1'b0;
    end else begin
      cur_state    <= nxt_state;
      time_q       <= time_d;
      presc_q      <= presc_d;
      magnetron_on <= (nxt_state == S_COOK);
      lamp_on      <= (nxt_state == S_COOK) || !door_closed;
      done         <= (nxt_state == S_DONE);
    end
  end

endmodule
